pipe_ctrl_sequencer: RTL

Control sequencer for the 4-stage (IF/ID/EX/WB) 16-bit pipelined core. It decodes the per-stage opcodes exported by the datapath and drives the PC, instruction-register, register-file and data-memory strobes. It tracks a valid bit per stage so that instructions squashed by a taken branch or jump never write state. It also owns run/halt sequencing: hold PC in reset, run, drain after HALT, and report done.

---
 rtl/pipe_ctrl_sequencer_if.sv | 34 +++
 rtl/pipe_ctrl_sequencer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_sequencer_if.sv
// Control/status bundle between the datapath and the pipeline control sequencer.
interface pipe_ctrl_sequencer_if;
  logic        start;
  logic [3:0]  if_opcode;
  logic [3:0]  id_opcode;
  logic [3:0]  ex_opcode;
  logic [3:0]  wb_opcode;
  logic        rs_less_zero;
  logic        pc_rst_n;
  logic        pc_inc;
  logic        pc_load;
  logic        pc_sel;
  logic        ir_wr;
  logic        rf_wr;
  logic        rf_wr_sel;
  logic        dmem_wr;
  logic        busy;
  logic        halted;
  logic [15:0] retired;

  // Datapath / stimulus side
  modport master (
    output start, if_opcode, id_opcode, ex_opcode, wb_opcode, rs_less_zero,
    input  pc_rst_n, pc_inc, pc_load, pc_sel, ir_wr, rf_wr, rf_wr_sel,
           dmem_wr, busy, halted, retired
  );

  // Sequencer side
  modport slave (
    input  start, if_opcode, id_opcode, ex_opcode, wb_opcode, rs_less_zero,
    output pc_rst_n, pc_inc, pc_load, pc_sel, ir_wr, rf_wr, rf_wr_sel,
           dmem_wr, busy, halted, retired
  );
endinterface

// File: rtl/pipe_ctrl_sequencer.sv
// Control sequencer for the 4-stage IF/ID/EX/WB core: per-stage valid
// tracking, branch/jump squashing, run/halt/drain sequencing, retire count.
module pipe_ctrl_sequencer (
  input  logic                  clk,
  input  logic                  rst_n,
  pipe_ctrl_sequencer_if.slave  bus
);
  localparam int STAGES = 3;
  localparam int S_IF = 0, S_ID = 1, S_EX = 2, S_WB = 3;

  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_BLZ  = 4'hA;
  localparam logic [3:0] OP_JAL  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [STAGES:0]   vld_pipe, vld_nxt;
  logic              brt;
  logic              drain_cnt, drain_cnt_nxt;
  logic [15:0]       retired;

  logic jal_ex, blz_tk, halt_id, ex_wr_op, ex_st_op, wb_counts;
  logic pc_rst_n, pc_inc, pc_load, pc_sel, ir_wr, rf_wr, rf_wr_sel, dmem_wr, busy, halted;

  // A JAL in EX redirects and wins over anything younger in ID.
  assign jal_ex    = vld_pipe[S_EX] && (bus.ex_opcode == OP_JAL);
  assign blz_tk    = vld_pipe[S_ID] && (bus.id_opcode == OP_BLZ) && brt && !jal_ex;
  assign halt_id   = vld_pipe[S_ID] && (bus.id_opcode == OP_HALT) && !jal_ex;
  assign ex_wr_op  = (bus.ex_opcode <= OP_LD) || (bus.ex_opcode == OP_JAL);
  assign ex_st_op  = (bus.ex_opcode == OP_ST);
  assign wb_counts = vld_pipe[S_WB] && !(bus.wb_opcode inside {4'hC, 4'hD, 4'hE});

  // Next state, next valid bits and all strobes.
  always_comb begin
    state_nxt     = state;
    vld_nxt       = '0;
    drain_cnt_nxt = drain_cnt;
    pc_rst_n      = 1'b0;
    pc_inc        = 1'b0;
    pc_load       = 1'b0;
    pc_sel        = 1'b0;
    ir_wr         = 1'b0;
    rf_wr         = 1'b0;
    rf_wr_sel     = 1'b0;
    dmem_wr       = 1'b0;
    busy          = 1'b0;
    halted        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt     = RUN;
          vld_nxt[S_IF] = 1'b1;  // instruction at PC 0 is fetched in the first RUN cycle
        end
      end
      RUN: begin
        pc_rst_n = 1'b1;
        ir_wr    = 1'b1;
        busy     = 1'b1;
        rf_wr    = vld_pipe[S_EX] && ex_wr_op;
        dmem_wr  = vld_pipe[S_EX] && ex_st_op;
        if (jal_ex) begin
          pc_load   = 1'b1;
          pc_sel    = 1'b1;
          rf_wr_sel = 1'b1;
        end else if (blz_tk) begin
          pc_load = 1'b1;
        end
        pc_inc        = !pc_load;
        vld_nxt[S_WB] = vld_pipe[S_EX];
        vld_nxt[S_EX] = vld_pipe[S_ID] && !jal_ex && !halt_id;
        vld_nxt[S_ID] = vld_pipe[S_IF] && !jal_ex && !blz_tk && !halt_id;
        vld_nxt[S_IF] = !halt_id;
        if (halt_id) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = 1'b0;
        end
      end
      DRAIN: begin
        pc_rst_n      = 1'b1;
        busy          = 1'b1;
        rf_wr         = vld_pipe[S_EX] && ex_wr_op;
        dmem_wr       = vld_pipe[S_EX] && ex_st_op;
        vld_nxt[S_WB] = vld_pipe[S_EX];
        vld_nxt[S_EX] = vld_pipe[S_ID];
        if (drain_cnt) state_nxt = DONE;
        else           drain_cnt_nxt = 1'b1;
      end
      DONE: begin
        pc_rst_n = 1'b1;
        halted   = 1'b1;
        if (bus.start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, valid pipe, branch flag and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vld_pipe  <= '0;
      brt       <= 1'b0;
      drain_cnt <= 1'b0;
      retired   <= '0;
    end else begin
      state     <= state_nxt;
      vld_pipe  <= vld_nxt;
      brt       <= bus.rs_less_zero;
      drain_cnt <= drain_cnt_nxt;
      if (wb_counts) retired <= retired + 16'd1;
    end
  end

  assign bus.pc_rst_n  = pc_rst_n;
  assign bus.pc_inc    = pc_inc;
  assign bus.pc_load   = pc_load;
  assign bus.pc_sel    = pc_sel;
  assign bus.ir_wr     = ir_wr;
  assign bus.rf_wr     = rf_wr;
  assign bus.rf_wr_sel = rf_wr_sel;
  assign bus.dmem_wr   = dmem_wr;
  assign bus.busy      = busy;
  assign bus.halted    = halted;
  assign bus.retired   = retired;
endmodule
